// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// counter_sequencer : command-driven controller for an up-counter datapath
//   (one-shot / periodic). Optional prescaler: COUNT_SEQ_PRESCALE_EN.
// Revision: 1.0
// ============================================================================
module counter_sequencer #(
  parameter int pWidth = 8,
  parameter int pPreW  = 16
) (
  input  logic              wClk,
  input  logic              wRst,
  input  logic              wCmdValid,
  output logic              rCmdReady,
  input  logic [1:0]        wCmdOp,
  input  logic [pWidth-1:0] wCmdLimit,
  input  logic [pPreW-1:0]  wCmdPre,
  output logic [pWidth-1:0] rCount,
  output logic              rBusy,
  output logic              rPaused,
  output logic              rDone,
  output logic              rWrap
);

  localparam logic [1:0] OP_ONESHOT  = 2'b00;
  localparam logic [1:0] OP_PERIODIC = 2'b01;
  localparam logic [1:0] OP_PAUSE    = 2'b10;
  localparam logic [1:0] OP_ABORT    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [pWidth-1:0]   limit_q, limit_nx;
  logic                periodic_q, periodic_nx;
  logic [pWidth-1:0]   count_nx;
  logic                wrap_nx;
  logic                accept;
  logic                tick;
  logic                pre_hold;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [pPreW-1:0]    pre_q, pre_nx;
  logic [pPreW-1:0]    pre_cnt, pre_cnt_nx;

  assign tick = (pre_cnt == pre_q);

  always_comb begin
    pre_nx     = pre_q;
    pre_cnt_nx = pre_cnt;
    if (accept && (wCmdOp == OP_ONESHOT || wCmdOp == OP_PERIODIC)) begin
      pre_nx = wCmdPre;
    end
    if (state == ST_LOAD) begin
      pre_cnt_nx = '0;
    end else if (state == ST_RUN && !pre_hold) begin
      pre_cnt_nx = tick ? '0 : pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge wClk) begin
    if (wRst) begin
      pre_q   <= '0;
      pre_cnt <= '0;
    end else begin
      pre_q   <= pre_nx;
      pre_cnt <= pre_cnt_nx;
    end
  end
`else
  logic unused_pre;
  assign unused_pre = ^wCmdPre;
  assign tick       = 1'b1;
`endif

  assign accept = wCmdValid & rCmdReady;
  // An accepted command owns the cycle: no count or prescale progress alongside it.
  assign pre_hold = accept;

  always_comb begin
    state_nx    = state;
    limit_nx    = limit_q;
    periodic_nx = periodic_q;
    count_nx    = rCount;
    wrap_nx     = 1'b0;
    if (accept) begin
      case (wCmdOp)
        OP_ONESHOT, OP_PERIODIC: begin
          state_nx    = ST_LOAD;
          limit_nx    = wCmdLimit;
          periodic_nx = (wCmdOp == OP_PERIODIC);
        end
        OP_PAUSE: begin
          if (state == ST_RUN) begin
            state_nx = ST_PAUSE;
          end else if (state == ST_PAUSE) begin
            state_nx = ST_RUN;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          count_nx = '0;
        end
      endcase
    end else begin
      case (state)
        ST_LOAD: begin
          state_nx = ST_RUN;
          count_nx = '0;
        end
        ST_RUN: begin
          if (tick) begin
            if (rCount == limit_q) begin
              if (periodic_q) begin
                count_nx = '0;
                wrap_nx  = 1'b1;
              end else begin
                state_nx = ST_DONE;
              end
            end else begin
              count_nx = rCount + 1'b1;
            end
          end
        end
        ST_DONE:  state_nx = ST_IDLE;
        ST_IDLE, ST_PAUSE: state_nx = state;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wClk) begin
    if (wRst) begin
      state      <= ST_IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      rCount     <= '0;
      rCmdReady  <= 1'b1;
      rBusy      <= 1'b0;
      rPaused    <= 1'b0;
      rDone      <= 1'b0;
      rWrap      <= 1'b0;
    end else begin
      state      <= state_nx;
      limit_q    <= limit_nx;
      periodic_q <= periodic_nx;
      rCount     <= count_nx;
      rCmdReady  <= !(state_nx == ST_LOAD || state_nx == ST_DONE);
      rBusy      <= (state_nx == ST_LOAD || state_nx == ST_RUN || state_nx == ST_PAUSE);
      rPaused    <= (state_nx == ST_PAUSE);
      rDone      <= (state_nx == ST_DONE);
      rWrap      <= wrap_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// Bench for counter_sequencer: directed scenarios followed by random commands,
// compared every cycle against a tick-counting reference model.
module tb_counter_sequencer;
  localparam int W  = 8;
  localparam int PW = 16;
`ifdef COUNT_SEQ_PRESCALE_EN
  localparam bit PRE_ON = 1'b1;
`else
  localparam bit PRE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  lim = '0;
  logic [PW-1:0] pre = '0;
  logic          ready, busy, paused, done, wrap;
  logic [W-1:0]  count;

  int total = 0;
  int bad   = 0;

  // Reference model: the count is derived from the number of ticks since RUN began.
  bit m_load, m_run, m_pause, m_done, m_wrap, m_periodic;
  int m_lim, m_pre, m_ticks, m_phase, m_count;

  always #5 clk = ~clk;

  counter_sequencer #(.pWidth(W), .pPreW(PW)) dut (
    .wClk(clk), .wRst(rst), .wCmdValid(valid), .rCmdReady(ready),
    .wCmdOp(op), .wCmdLimit(lim), .wCmdPre(pre), .rCount(count),
    .rBusy(busy), .rPaused(paused), .rDone(done), .rWrap(wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_run = 0; m_pause = 0; m_done = 0; m_wrap = 0; m_periodic = 0;
    m_lim = 0; m_pre = 0; m_ticks = 0; m_phase = 0; m_count = 0;
  endtask

  task automatic model_step(input bit acc, input logic [1:0] o, input int l, input int p);
    bit tk;
    m_wrap = 0;
    if (m_load) begin
      m_load = 0; m_run = 1; m_ticks = 0; m_phase = 0; m_count = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (acc) begin
      if (o <= 2'd1) begin
        m_load = 1; m_run = 0; m_pause = 0;
        m_lim = l; m_pre = p; m_periodic = o[0];
      end else if (o == 2'd2) begin
        if (m_run) begin m_run = 0; m_pause = 1; end
        else if (m_pause) begin m_pause = 0; m_run = 1; end
      end else begin
        m_run = 0; m_pause = 0; m_count = 0;
      end
    end else if (m_run) begin
      tk = !PRE_ON || (m_phase == m_pre);
      m_phase = tk ? 0 : m_phase + 1;
      if (tk) begin
        m_ticks++;
        if (!m_periodic && m_ticks == m_lim + 1) begin
          m_run = 0; m_done = 1;
        end else begin
          m_count = m_periodic ? m_ticks % (m_lim + 1) : m_ticks;
          m_wrap  = m_periodic && (m_ticks % (m_lim + 1) == 0);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("count",  32'(count),  32'(m_count));
    chk("busy",   32'(busy),   32'(m_load || m_run || m_pause));
    chk("paused", 32'(paused), 32'(m_pause));
    chk("done",   32'(done),   32'(m_done));
    chk("wrap",   32'(wrap),   32'(m_wrap));
    chk("ready",  32'(ready),  32'(!(m_load || m_done)));
  endtask

  // One clock: drive inputs, advance model at the edge, check #1 later.
  task automatic cyc(input bit v, input logic [1:0] o, input int l, input int p);
    bit acc;
    valid = v; op = o; lim = W'(l); pre = PW'(p);
    acc = v && !(m_load || m_done);
    @(posedge clk);
    if (rst) model_reset();
    else model_step(acc, o, l, p);
    #1;
    check_all();
  endtask

  // Idle cycles after an accept at edge 0; reports the first edge showing rDone.
  task automatic find_done(input int n, output int edge_at);
    edge_at = 0;
    for (int i = 1; i <= n; i++) begin
      cyc(0, 2'd0, 0, 0);
      if (done === 1'b1 && edge_at == 0) edge_at = i;
    end
  endtask

  initial begin
    int de;
    int wraps;
    model_reset();
    // Reset state
    rst = 1; cyc(0, 2'd0, 0, 0); rst = 0;

    // One-shot L=5: counts 0..5, rDone after edge 7
    cyc(1, 2'd0, 5, 0);
    find_done(9, de);
    chk("t2_done_edge", 32'(de), 32'd7);
    chk("t2_hold", 32'(count), 32'd5);

    // Periodic L=3: one wrap every 4 cycles
    cyc(1, 2'd1, 3, 0);
    wraps = 0;
    for (int i = 1; i <= 17; i++) begin
      cyc(0, 2'd0, 0, 0);
      if (wrap === 1'b1) wraps++;
      chk("t3_nodone", 32'(done), 32'd0);
    end
    chk("t3_wraps", 32'(wraps), 32'd4);
    cyc(1, 2'd3, 0, 0);

    // Pause at count 2 for 10 cycles, resume continues
    cyc(1, 2'd0, 9, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'd0, 0, 0);
    chk("t4_at2", 32'(count), 32'd2);
    cyc(1, 2'd2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 2'd0, 0, 0);
      chk("t4_frozen", 32'(count), 32'd2);
    end
    cyc(1, 2'd2, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'd0, 0, 0);
    chk("t4_resume", 32'(count), 32'd5);

    // Reset mid-run at count 4
    cyc(1, 2'd0, 9, 0);
    for (int i = 0; i < 5; i++) cyc(0, 2'd0, 0, 0);
    chk("t1_at4", 32'(count), 32'd4);
    rst = 1; cyc(0, 2'd0, 0, 0); rst = 0;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ready", 32'(ready), 32'd1);

    // ABORT on the periodic terminal tick
    cyc(1, 2'd1, 3, 0);
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 0, 0);
    chk("t5_atL", 32'(count), 32'd3);
    cyc(1, 2'd3, 0, 0);
    chk("t5_nowrap", 32'(wrap), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_zero", 32'(count), 32'd0);
    cyc(1, 2'd0, 0, 0);
    find_done(4, de);
    chk("t5_l0_done_edge", 32'(de), 32'd2);

    // L=2 P=2: prescaled or not
    cyc(1, 2'd0, 2, 2);
    find_done(14, de);
    chk("t6_done_edge", 32'(de), PRE_ON ? 32'd10 : 32'd4);

    // Full-range limit
    cyc(1, 2'd0, 255, 0);
    find_done(260, de);
    chk("tmax_done_edge", 32'(de), 32'd257);
    chk("tmax_hold", 32'(count), 32'd255);

    // Random commands
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cyc(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 6)),
          int'($urandom_range(0, 3)));
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
